// File: rtl/cache_pkg.sv
// Shared constants and types for the cache-coherent common-bus subsystem.
package cache_pkg;

    localparam int ADDRESSSIZE      = 32;
    localparam int INDEX_SIZE       = 8;
    localparam int HOLD_MAX_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PROC_OWN  = 2'd1,
        ST_SNOOP_OWN = 2'd2,
        ST_MEM_OWN   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after the pointer, as one-hot and index.
module rr_pick #(
    parameter int NUM_PROC = 4,
    parameter int IW       = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
    input  logic [NUM_PROC-1:0] i_req,
    input  logic [IW-1:0]       i_ptr,
    output logic [NUM_PROC-1:0] o_onehot,
    output logic [IW-1:0]       o_idx,
    output logic                o_valid
);

    localparam logic [IW:0]         NUM_W        = (IW+1)'(NUM_PROC);
    localparam logic [NUM_PROC-1:0] ONE_HOT_BASE = NUM_PROC'(1);

    logic [NUM_PROC-1:0] w_rot;
    logic [IW:0]         w_sum;

    // Rotate requests so that bit k corresponds to core (ptr + k) mod NUM_PROC.
    always_comb begin
        w_rot = NUM_PROC'({i_req, i_req} >> i_ptr);
    end

    // Nearest rotated requester wins; scanning downward leaves the smallest offset.
    always_comb begin
        o_valid = 1'b0;
        w_sum   = '0;
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = {1'b0, i_ptr} + (IW+1)'(k);
            end else begin
                w_sum   = w_sum;
            end
        end
        if (w_sum >= NUM_W) begin
            o_idx = IW'(w_sum - NUM_W);
        end else begin
            o_idx = w_sum[IW-1:0];
        end
        if (o_valid) begin
            o_onehot = ONE_HOT_BASE << o_idx;
        end else begin
            o_onehot = '0;
        end
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin processor ownership with nested snoop / memory
// data-return grants, registered one-hot grant outputs and a sticky hold timeout.
module com_bus_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PROC-1:0] Com_Bus_Req_proc,
    input  logic [NUM_PROC-1:0] Com_Bus_Req_snoop,
    input  logic                Mem_snoop_req,
    output logic [NUM_PROC-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_PROC-1:0] Com_Bus_Gnt_snoop_vec,
    output logic                Com_Bus_Gnt_snoop,
    output logic                Mem_snoop_gnt,
    output logic                Bus_timeout
);

    localparam int IW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int CW = $clog2(HOLD_MAX + 1);

    localparam logic [IW-1:0]       LAST_IDX     = IW'(NUM_PROC - 1);
    localparam logic [IW-1:0]       ONE_IDX      = IW'(1);
    localparam logic [CW-1:0]       HOLD_LIMIT   = CW'(HOLD_MAX);
    localparam logic [CW-1:0]       CNT_ONE      = CW'(1);
    localparam logic [NUM_PROC-1:0] ONE_HOT_BASE = NUM_PROC'(1);

    bus_state_e          r_state, w_state_nxt;
    logic [IW-1:0]       r_owner, w_owner_nxt;
    logic [IW-1:0]       r_snooper, w_snooper_nxt;
    logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [CW-1:0]       r_hold_cnt, w_hold_cnt_nxt;
    logic                r_timeout;
    logic [NUM_PROC-1:0] r_gnt_proc, w_gnt_proc_nxt;
    logic [NUM_PROC-1:0] r_gnt_snoop_vec, w_gnt_snoop_vec_nxt;
    logic                r_gnt_snoop;
    logic                r_gnt_mem, w_gnt_mem_nxt;
    logic                w_gnt_change;

    logic [NUM_PROC-1:0] w_pick_onehot;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_valid;

    logic [NUM_PROC-1:0] w_owner_onehot;
    logic [NUM_PROC-1:0] w_snoop_elig;
    logic                w_snoop_hit;
    logic [IW-1:0]       w_snoop_idx;

    rr_pick #(
        .NUM_PROC (NUM_PROC),
        .IW       (IW)
    ) u_rr_pick (
        .i_req    (Com_Bus_Req_proc),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Fixed-priority snoop select; the current owner's own snoop bit never competes.
    always_comb begin
        w_owner_onehot = ONE_HOT_BASE << r_owner;
        w_snoop_elig   = Com_Bus_Req_snoop & ~w_owner_onehot;
        w_snoop_hit    = |w_snoop_elig;
        w_snoop_idx    = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (w_snoop_elig[i]) begin
                w_snoop_idx = IW'(i);
            end else begin
                w_snoop_idx = w_snoop_idx;
            end
        end
    end

    // Next-state logic; an owner drop takes precedence over any secondary request.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_snooper_nxt = r_snooper;
        w_rr_ptr_nxt  = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_PROC_OWN;
                    w_owner_nxt = w_pick_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PROC_OWN: begin
                if (!Com_Bus_Req_proc[r_owner]) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = (r_owner == LAST_IDX) ? '0 : (r_owner + ONE_IDX);
                end else if (w_snoop_hit) begin
                    w_state_nxt   = ST_SNOOP_OWN;
                    w_snooper_nxt = w_snoop_idx;
                end else if (Mem_snoop_req) begin
                    w_state_nxt = ST_MEM_OWN;
                end else begin
                    w_state_nxt = ST_PROC_OWN;
                end
            end
            ST_SNOOP_OWN: begin
                if (!Com_Bus_Req_snoop[r_snooper]) begin
                    w_state_nxt = ST_PROC_OWN;
                end else begin
                    w_state_nxt = ST_SNOOP_OWN;
                end
            end
            ST_MEM_OWN: begin
                if (!Mem_snoop_req) begin
                    w_state_nxt = ST_PROC_OWN;
                end else begin
                    w_state_nxt = ST_MEM_OWN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant decode from the next state so the registered grants line up with it.
    always_comb begin
        w_gnt_proc_nxt      = '0;
        w_gnt_snoop_vec_nxt = '0;
        w_gnt_mem_nxt       = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_gnt_proc_nxt = '0;
            end
            ST_PROC_OWN: begin
                w_gnt_proc_nxt = ONE_HOT_BASE << w_owner_nxt;
            end
            ST_SNOOP_OWN: begin
                w_gnt_proc_nxt      = ONE_HOT_BASE << w_owner_nxt;
                w_gnt_snoop_vec_nxt = ONE_HOT_BASE << w_snooper_nxt;
            end
            ST_MEM_OWN: begin
                w_gnt_proc_nxt = ONE_HOT_BASE << w_owner_nxt;
                w_gnt_mem_nxt  = 1'b1;
            end
            default: begin
                w_gnt_proc_nxt = '0;
            end
        endcase
    end

    // Hold counter restarts on any grant change and only advances while the bus is owned.
    always_comb begin
        w_gnt_change = (w_gnt_proc_nxt != r_gnt_proc) ||
                       (w_gnt_snoop_vec_nxt != r_gnt_snoop_vec) ||
                       (w_gnt_mem_nxt != r_gnt_mem);
        if (w_gnt_change) begin
            w_hold_cnt_nxt = '0;
        end else if ((r_state != ST_IDLE) && (r_hold_cnt != HOLD_LIMIT)) begin
            w_hold_cnt_nxt = r_hold_cnt + CNT_ONE;
        end else begin
            w_hold_cnt_nxt = r_hold_cnt;
        end
    end

    // State, index, grant and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_owner         <= '0;
            r_snooper       <= '0;
            r_rr_ptr        <= '0;
            r_hold_cnt      <= '0;
            r_timeout       <= 1'b0;
            r_gnt_proc      <= '0;
            r_gnt_snoop_vec <= '0;
            r_gnt_snoop     <= 1'b0;
            r_gnt_mem       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_owner         <= w_owner_nxt;
            r_snooper       <= w_snooper_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_gnt_proc      <= w_gnt_proc_nxt;
            r_gnt_snoop_vec <= w_gnt_snoop_vec_nxt;
            r_gnt_snoop     <= |w_gnt_snoop_vec_nxt;
            r_gnt_mem       <= w_gnt_mem_nxt;
            if (w_hold_cnt_nxt == HOLD_LIMIT) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    assign Com_Bus_Gnt_proc      = r_gnt_proc;
    assign Com_Bus_Gnt_snoop_vec = r_gnt_snoop_vec;
    assign Com_Bus_Gnt_snoop     = r_gnt_snoop;
    assign Mem_snoop_gnt         = r_gnt_mem;
    assign Bus_timeout           = r_timeout;

endmodule
